// File: rtl/uart_tx_arbiter_if.sv
// Bundle of producer-side and transmitter-side signals of uart_tx_arbiter.
// master: the surrounding system (producers + TX); slave: the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] dane;
  logic [2*N_REQ-1:0] parz_cfg;
  logic [N_REQ-1:0]   ack;
  logic [2:0]         grant_id;
  logic               zajety;
  logic               done;
  logic [7:0]         slowo_trans;
  logic               start_trans;
  logic               czy_parz;
  logic               jaki_parz;
  logic               transmisja;
  logic               blad;

  modport master (
    output req, dane, parz_cfg, transmisja,
    input  ack, grant_id, zajety, done, slowo_trans, start_trans,
           czy_parz, jaki_parz, blad
  );

  modport slave (
    input  req, dane, parz_cfg, transmisja,
    output ack, grant_id, zajety, done, slowo_trans, start_trans,
           czy_parz, jaki_parz, blad
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Optional start-timeout watchdog enabled by defining TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int START_LEN = 4,
  parameter int GAP       = 0,
  parameter int TIMEOUT   = 128
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_BUSY,
    S_GAP
  } state_t;

  localparam int unsigned NR = N_REQ;
  localparam int CW = 16;
  localparam logic [CW-1:0] LP_START_LEN = CW'(START_LEN);
  localparam logic [CW-1:0] LP_GAP_LAST  = CW'(GAP - 1);

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic [2:0]       r_grant_id;
  logic             r_zajety;
  logic             r_done;
  logic [7:0]       r_slowo;
  logic             r_start;
  logic             r_czy;
  logic             r_jaki;

  logic             w_gnt_vld;
  logic [2:0]       w_gnt_idx;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic [7:0]       w_gnt_byte;
  logic [1:0]       w_gnt_cfg;

`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tcnt;
  logic          r_blad;
`endif

  // First asserted request after the pointer wins; scanning ptr+1 .. ptr+N_REQ.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    w_gnt_vld    = 1'b0;
    w_gnt_idx    = '0;
    w_gnt_onehot = '0;
    w_gnt_byte   = '0;
    w_gnt_cfg    = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (int'(r_ptr) + k) % NR;
      if (!w_gnt_vld && bus.req[idx]) begin
        w_gnt_vld         = 1'b1;
        w_gnt_idx         = 3'(idx);
        w_gnt_onehot[idx] = 1'b1;
        w_gnt_byte        = bus.dane[8*idx +: 8];
        w_gnt_cfg         = bus.parz_cfg[2*idx +: 2];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'(N_REQ - 1);
      r_cnt      <= '0;
      r_ack      <= '0;
      r_grant_id <= '0;
      r_zajety   <= 1'b0;
      r_done     <= 1'b0;
      r_slowo    <= '0;
      r_start    <= 1'b1;
      r_czy      <= 1'b0;
      r_jaki     <= 1'b0;
`ifdef TX_TIMEOUT_EN
      r_tcnt     <= '0;
      r_blad     <= 1'b0;
`endif
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A frame left running across reset keeps the line busy; hold off.
          if (w_gnt_vld && !bus.transmisja) begin
            r_ack      <= w_gnt_onehot;
            r_grant_id <= w_gnt_idx;
            r_ptr      <= w_gnt_idx;
            r_slowo    <= w_gnt_byte;
            r_jaki     <= w_gnt_cfg[1];
            r_czy      <= w_gnt_cfg[0];
            r_start    <= 1'b0;
            r_zajety   <= 1'b1;
            r_cnt      <= CW'(1);
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // r_cnt holds the number of low cycles already driven.
          if (r_cnt == LP_START_LEN) begin
            r_start <= 1'b1;
            r_state <= S_WAIT_START;
`ifdef TX_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_START: begin
          if (bus.transmisja) begin
            r_state <= S_BUSY;
          end
`ifdef TX_TIMEOUT_EN
          else if (r_tcnt == LP_TMO_LAST) begin
            r_blad <= 1'b1;
            r_done <= 1'b1;
            r_start <= 1'b1;
            if (GAP > 0) begin
              r_cnt   <= '0;
              r_state <= S_GAP;
            end else begin
              r_zajety <= 1'b0;
              r_state  <= S_IDLE;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        S_BUSY: begin
          if (!bus.transmisja) begin
            r_done <= 1'b1;
            if (GAP > 0) begin
              r_cnt   <= '0;
              r_state <= S_GAP;
            end else begin
              r_zajety <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            r_zajety <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_start  <= 1'b1;
          r_zajety <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.grant_id    = r_grant_id;
  assign bus.zajety      = r_zajety;
  assign bus.done        = r_done;
  assign bus.slowo_trans = r_slowo;
  assign bus.start_trans = r_start;
  assign bus.czy_parz    = r_czy;
  assign bus.jaki_parz   = r_jaki;
`ifdef TX_TIMEOUT_EN
  assign bus.blad        = r_blad;
`else
  assign bus.blad        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: main instance (GAP=0) plus a GAP=10 instance.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int SL  = 4;
  localparam int TMO = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) m_if ();
  uart_tx_arbiter_if #(.N_REQ(N)) g_if ();

  uart_tx_arbiter #(.N_REQ(N), .START_LEN(SL), .GAP(0), .TIMEOUT(TMO)) u_dut (
    .CLK(clk), .RST(rst), .bus(m_if.slave));
  uart_tx_arbiter #(.N_REQ(N), .START_LEN(SL), .GAP(10), .TIMEOUT(TMO)) u_gap (
    .CLK(clk), .RST(rst), .bus(g_if.slave));

  typedef struct {
    logic [N-1:0] ack;
    logic [2:0]   id;
    logic [7:0]   byte_v;
    logic [1:0]   cfg;
  } exp_t;

  exp_t       q_ack[$];
  logic [2:0] q_done[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic [N-1:0] a, input logic [2:0] id, input logic [7:0] b,
                      input logic [1:0] cfg, input bit with_done);
    exp_t e;
    e.ack = a; e.id = id; e.byte_v = b; e.cfg = cfg;
    q_ack.push_back(e);
    if (with_done) q_done.push_back(id);
  endtask

  // Producers release their request on the acknowledge they receive.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      m_if.req = m_if.req & ~m_if.ack;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((q_ack.size() != 0 || q_done.size() != 0 || m_if.zajety) && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, q_ack.size() + q_done.size(), 0);
  endtask

  // Transmitter model: rises 2 cycles after start release, busy for 12 cycles.
  bit tx_auto = 1'b1;
  int tx_delay = 0;
  int tx_busy = 0;
  logic st_prev = 1'b1;
  initial begin
    m_if.transmisja = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) begin
          m_if.transmisja = 1'b1;
          tx_busy = 12;
        end
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) m_if.transmisja = 1'b0;
      end else if (tx_auto && !st_prev && m_if.start_trans) begin
        tx_delay = 2;
      end
      st_prev = m_if.start_trans;
    end
  end

  // Monitor: pops expectations whenever the DUT acknowledges or completes a frame.
  exp_t mon_e;
  int   low_cnt = 0;
  logic prev_tx = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
    end else begin
      if (m_if.ack != '0) begin
        if (q_ack.size() == 0) begin
          check("unexpected_ack", 32'(m_if.ack), 0);
        end else begin
          mon_e = q_ack.pop_front();
          check("ack_vec", 32'(m_if.ack), 32'(mon_e.ack));
          check("grant_id", 32'(m_if.grant_id), 32'(mon_e.id));
          check("slowo_trans", 32'(m_if.slowo_trans), 32'(mon_e.byte_v));
          check("parity_cfg", 32'({m_if.jaki_parz, m_if.czy_parz}), 32'(mon_e.cfg));
          check("start_low_at_ack", 32'(m_if.start_trans), 0);
          check("zajety_at_ack", 32'(m_if.zajety), 1);
          check("tx_idle_at_grant", 32'(prev_tx), 0);
        end
      end
      if (m_if.done) begin
        if (q_done.size() == 0) begin
          check("unexpected_done", 32'(m_if.done), 0);
        end else begin
          check("done_grant_id", 32'(m_if.grant_id), 32'(q_done.pop_front()));
          check("done_slowo_stable", 32'(m_if.slowo_trans), 32'(mon_e.byte_v));
          check("done_parity_stable", 32'({m_if.jaki_parz, m_if.czy_parz}), 32'(mon_e.cfg));
        end
      end
      if (!m_if.start_trans) begin
        low_cnt++;
      end else if (low_cnt > 0) begin
        check("start_low_len", low_cnt, SL);
        low_cnt = 0;
      end
    end
    prev_tx = m_if.transmisja;
  end

  initial begin
    int k;
    int viol;
    int zh;
    m_if.req = '0;
    m_if.dane = {8'h44, 8'h33, 8'h22, 8'hA5};
    m_if.parz_cfg = 8'b00_00_00_01;
    g_if.req = '0;
    g_if.dane = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
    g_if.parz_cfg = '0;
    g_if.transmisja = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_start_trans", 32'(m_if.start_trans), 1);
    check("rst_ack", 32'(m_if.ack), 0);
    check("rst_zajety", 32'(m_if.zajety), 0);
    check("rst_done", 32'(m_if.done), 0);
    check("rst_grant_id", 32'(m_if.grant_id), 0);
    check("rst_slowo", 32'(m_if.slowo_trans), 0);
    check("rst_parity", 32'({m_if.jaki_parz, m_if.czy_parz}), 0);
    check("rst_blad", 32'(m_if.blad), 0);

    // 1: single source, one-cycle ack latency
    push(4'b0001, 3'd0, 8'hA5, 2'b01, 1'b1);
    m_if.req = 4'b0001;
    tick(1);
    check("t1_ack_latency", 32'(m_if.ack), 32'(4'b0001));
    wait_drain("t1_drain", 200);

    // 2: round-robin order 0,1,3 then wrap to 0, then 2
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_if.dane = {8'h44, 8'h33, 8'h22, 8'h11};
    m_if.parz_cfg = {2'b11, 2'b00, 2'b10, 2'b01};
    push(4'b0001, 3'd0, 8'h11, 2'b01, 1'b1);
    push(4'b0010, 3'd1, 8'h22, 2'b10, 1'b1);
    push(4'b1000, 3'd3, 8'h44, 2'b11, 1'b1);
    m_if.req = 4'b1011;
    wait_drain("t2_drain_a", 400);
    push(4'b0001, 3'd0, 8'h11, 2'b01, 1'b1);
    push(4'b0100, 3'd2, 8'h33, 2'b00, 1'b1);
    m_if.req = 4'b0101;
    wait_drain("t2_drain_b", 400);

    // 4: reset during BUSY; no done, next grant only once the line is idle
    push(4'b1000, 3'd3, 8'h44, 2'b11, 1'b0);
    m_if.req = 4'b1000;
    k = 0;
    while (!m_if.transmisja && k < 100) begin tick(1); k++; end
    check("t4_tx_started", 32'(m_if.transmisja), 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4_start_after_rst", 32'(m_if.start_trans), 1);
    check("t4_zajety_after_rst", 32'(m_if.zajety), 0);
    check("t4_grant_after_rst", 32'(m_if.grant_id), 0);
    push(4'b0100, 3'd2, 8'h33, 2'b00, 1'b1);
    m_if.req = 4'b0100;
    wait_drain("t4_drain", 200);

    // 6: no requests for 100 cycles
    m_if.req = '0;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!m_if.start_trans || m_if.ack != '0 || m_if.zajety) viol++;
    end
    check("t6_idle_quiet", viol, 0);

`ifdef TX_TIMEOUT_EN
    // 5: transmitter never answers
    tx_auto = 1'b0;
    push(4'b0001, 3'd0, 8'h11, 2'b01, 1'b1);
    m_if.req = 4'b0001;
    k = 0;
    while (m_if.start_trans && k < 20) begin tick(1); k++; end
    while (!m_if.start_trans && k < 40) begin tick(1); k++; end
    k = 0;
    while (!m_if.blad && k < 300) begin tick(1); k++; end
    check("t5_timeout_cycles", k, TMO);
    tick(5);
    check("t5_blad_sticky", 32'(m_if.blad), 1);
    check("t5_back_idle", 32'(m_if.zajety), 0);
    wait_drain("t5_drain", 50);
    tx_auto = 1'b1;
`endif

    // 3: GAP=10 instance, two sources back to back
    @(negedge clk);
    g_if.req = 4'b0011;
    k = 0;
    do begin @(negedge clk); k++; end while (g_if.ack == '0 && k < 20);
    check("t3_first_ack", 32'(g_if.ack), 32'(4'b0001));
    g_if.req = 4'b0010;
    k = 0;
    while (!g_if.start_trans && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    g_if.transmisja = 1'b1;
    repeat (5) @(negedge clk);
    g_if.transmisja = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!g_if.done && k < 20);
    check("t3_done_seen", 32'(g_if.done), 1);
    check("t3_zajety_at_done", 32'(g_if.zajety), 1);
    zh = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k <= 9 && g_if.zajety) zh++;
    end while (g_if.ack == '0 && k < 40);
    check("t3_done_to_ack_gap", k - 1, 10);
    check("t3_zajety_held", zh, 9);
    check("t3_second_ack", 32'(g_if.ack), 32'(4'b0010));
    check("t3_second_byte", 32'(g_if.slowo_trans), 32'(8'hB2));
    g_if.req = '0;
    k = 0;
    while (!g_if.start_trans && k < 20) begin @(negedge clk); k++; end
    g_if.transmisja = 1'b1;
    repeat (3) @(negedge clk);
    g_if.transmisja = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!g_if.done && k < 20);
    check("t3_second_done", 32'(g_if.done), 1);

    tick(5);
    check("final_queues_empty", q_ack.size() + q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected run to complete", n_chk);
    $fatal(1, "global timeout");
  end
endmodule
